display7seg_2de5_mux: RTL and testbench
=======================================

// Module: display7seg_2de5_mux
// PURPOSE
//  Parametrised successor to the single-digit 2-of-5 -> 7-segment decoder.
//  - Latches N_DIGITS 2-of-5 codes on a load strobe and validates each one internally.
//  - Drives one shared, time-multiplexed, active-low 7-segment bus with active-low digit enables.
//  - Optionally blanks leading zeros and inserts an anti-ghosting blank gap in every digit slot.
//  - Sits between the keypad/code-entry logic and the board's multi-digit display.
// PARAMETERS
//  N_DIGITS   4   number of digits; digit 0 is least significant; must be >= 1
//  PRESCALE   50000  clk cycles per digit slot; must be >= 2
//  BLANK_CYC  2   cycles at the start of each slot with all outputs off; must be < PRESCALE
//  LZB        1   1 = blank leading zeros, 0 = show all digits
// PORTS
//  clk      in   1            system clock, rising edge
//  rst_n    in   1            asynchronous reset, active low
//  load     in   1            when 1, code is captured at the clk edge
//  code     in   5*N_DIGITS   code[5i+4:5i] = {CH7,CH6,CH5,CH4,CH3} of digit i
//  seg_n    out  7            segments {A,B,C,D,E,F,G}, seg_n[6]=A; 0 = lit
//  dig_n    out  N_DIGITS     one-hot-low digit enable; 0 = digit on
//  err      out  N_DIGITS     err[i]=1 when latched digit i is not a valid 2-of-5 code
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - code regs = 0, loaded=0, prescaler=0, index=0.
//   - seg_n=7'h7F, dig_n=all 1s, err=0.
//  Reset assert mid-operation: outputs go to reset values immediately, without waiting for clk.
//  Capture:
//   - load=1 at an edge latches all of code and sets loaded=1.
//   - err updates on that same edge (registered).
//   - The new glyph appears at the next output update; latency is 1 clk.
//   - load does not disturb the prescaler or index.
//  Validity: a code is valid when exactly two of its 5 bits are 1. All 10 such codes map to digits:
//   01100=0, 11000=1, 10100=2, 10010=3, 01010=4, 00110=5, 10001=6, 01001=7, 00101=8, 00011=9
//  Glyphs (seg_n, active low):
//   - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
//   - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
//   - invalid digit shows E=0110000
//  Scan:
//   - Prescaler counts 0..PRESCALE-1 and wraps to 0.
//   - On the terminal-count cycle, index advances; after N_DIGITS-1 it wraps to 0.
//   - seg_n/dig_n are registered and are a function of the next-cycle (prescaler, index).
//   - Slot output: dig_n[index]=0 with that digit's glyph, except in the cases below.
//  Blank gap: while prescaler < BLANK_CYC, seg_n=7'h7F and dig_n=all 1s. BLANK_CYC=0 disables the gap.
//  Leading-zero blanking (LZB=1):
//   - Digit i>0 is blanked (dig_n[i]=1, seg_n=7F) when it and every digit above it are valid zeros.
//   - Digit 0 is never blanked.
//   - An invalid digit stops the blanking, so it and every digit below it are shown.
//  Before the first load (loaded=0): display stays fully blank and err=0.
//  N_DIGITS=1: index stays 0 and the digit is enabled every slot except during the blank gap.
//  At most one dig_n bit is 0 in any cycle.
// TESTING
//  - Reset: hold rst_n=0 for 3 clk -> seg_n=7F, dig_n=F, err=0; release without load -> stays blank.
//  - Glyph sweep (N=4, PRESCALE=4, BLANK_CYC=1, LZB=0): load each valid code on digit 0 -> in
//    digit-0 slot, 00101 gives seg_n=0000000 and 01001 gives 0001111; dig_n cycles E,D,B,7 and each
//    slot is 3 cycles lit after 1 blank cycle.
//  - Invalid codes: load digit 2 = 00000, then 11100 -> err=0100, slot 2 shows 0110000; reload
//    valid -> err=0000.
//  - LZB=1: digits {3..0} = 0,0,4,0 -> digits 3 and 2 stay blank, digits 1 and 0 show 1001100 and
//    0000001; load {0,0,0,0} -> only digit 0 is lit.
//  - Load mid-slot: load new code while dig_n=1101 -> prescaler/index unchanged, glyph changes 1
//    clk later, err is updated on the load edge.
//  - Async reset mid-scan: drop rst_n between clk edges -> outputs go to 7F/F/0 before the next
//    edge; after release, scan restarts at digit 0 and the display stays blank until load.

Source files
------------

// File: rtl/display7seg_2de5_mux_if.sv
// Display bus between code-entry logic and the multiplexed 2-of-5 display driver.
interface display7seg_2de5_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load;
  logic [5*N_DIGITS-1:0]   code;
  logic [6:0]              seg_n;
  logic [N_DIGITS-1:0]     dig_n;
  logic [N_DIGITS-1:0]     err;

  modport master (output load, output code, input seg_n, input dig_n, input err);
  modport slave  (input load, input code, output seg_n, output dig_n, output err);
endinterface

// File: rtl/display7seg_2de5_mux.sv
// Multi-digit 2-of-5 code latch with validation, leading-zero blanking and a
// time-multiplexed active-low 7-segment scan with an anti-ghosting blank gap.
module display7seg_2de5_mux #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned LZB       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  display7seg_2de5_mux_if.slave   bus
);

  localparam int unsigned CW = 5 * N_DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [4:0] CODE_ZERO = 5'b01100;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  logic [CW-1:0]       code_q;
  logic                loaded_q;
  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       pre_nxt;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_nxt;
  logic [6:0]          seg_q;
  logic [6:0]          seg_d;
  logic [N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0] dig_d;
  logic [N_DIGITS-1:0] err_q;
  logic [N_DIGITS-1:0] err_d;
  logic [N_DIGITS-1:0] lz_blank;
  logic                lz_run;
  logic [4:0]          sel_code;
  logic                sel_blank;
  logic [N_DIGITS-1:0] sel_hot;
  logic                in_gap;

  // 2-of-5 code to active-low glyph; anything else shows 'E'.
  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'b01100: glyph = 7'h01;
      5'b11000: glyph = 7'h4F;
      5'b10100: glyph = 7'h12;
      5'b10010: glyph = 7'h06;
      5'b01010: glyph = 7'h4C;
      5'b00110: glyph = 7'h24;
      5'b10001: glyph = 7'h20;
      5'b01001: glyph = 7'h0F;
      5'b00101: glyph = 7'h00;
      5'b00011: glyph = 7'h04;
      default:  glyph = 7'h30;
    endcase
  endfunction

  // Scan counters: prescaler wraps each slot, index advances on terminal count.
  always_comb begin
    pre_nxt = pre_q + PW'(1);
    idx_nxt = idx_q;
    if (pre_q == PW'(PRESCALE - 1)) begin
      pre_nxt = '0;
      idx_nxt = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Leading-zero mask: a digit above 0 blanks while it and all higher digits are valid zeros.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (code_q[5*i +: 5] == CODE_ZERO);
      if ((LZB != 0) && (i > 0)) lz_blank[i] = lz_run;
    end
  end

  // Next-cycle slot selection and registered-output next values.
  always_comb begin
    sel_code  = '0;
    sel_blank = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == idx_nxt) begin
        sel_code   = code_q[5*i +: 5];
        sel_blank  = lz_blank[i];
        sel_hot[i] = 1'b1;
      end
    end
    in_gap = (BLANK_CYC != 0) && (32'(pre_nxt) < BLANK_CYC);
    seg_d  = SEG_OFF;
    dig_d  = '1;
    if (loaded_q && !in_gap && !sel_blank) begin
      seg_d = glyph(sel_code);
      dig_d = ~sel_hot;
    end
  end

  // Validity of the incoming codes, latched alongside them.
  always_comb begin
    err_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      err_d[i] = ($countones(bus.code[5*i +: 5]) != 2);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= '0;
      loaded_q <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= '1;
      err_q    <= '0;
    end else begin
      pre_q <= pre_nxt;
      idx_q <= idx_nxt;
      seg_q <= seg_d;
      dig_q <= dig_d;
      if (bus.load) begin
        code_q   <= bus.code;
        loaded_q <= 1'b1;
        err_q    <= err_d;
      end
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.dig_n = dig_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_display7seg_2de5_mux.sv
// Table-driven bench for the multiplexed 2-of-5 display driver.
module tb_display7seg_2de5_mux;

  localparam logic [4:0] Z  = 5'b01100;
  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] G0 = 7'h01;

  typedef struct {
    logic [19:0] code;
    logic [27:0] e0;   // expected glyph per digit {d3,d2,d1,d0}, LZB=0; 7F = never lit
    logic [27:0] e1;   // same for LZB=1
    logic [3:0]  err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [19:0] code;

  int checks = 0;
  int errors = 0;

  logic [6:0] seen [2][4];
  int         lit  [2][4];
  int         prev_on;

  vec_t vecs [19];

  display7seg_2de5_mux_if #(.N_DIGITS(4)) bus0 ();
  display7seg_2de5_mux_if #(.N_DIGITS(4)) bus1 ();
  display7seg_2de5_mux_if #(.N_DIGITS(1)) bus2 ();

  assign bus0.load = load;
  assign bus0.code = code;
  assign bus1.load = load;
  assign bus1.code = code;
  assign bus2.load = load;
  assign bus2.code = code[4:0];

  display7seg_2de5_mux #(.N_DIGITS(4), .PRESCALE(4), .BLANK_CYC(1), .LZB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  display7seg_2de5_mux #(.N_DIGITS(4), .PRESCALE(4), .BLANK_CYC(1), .LZB(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  display7seg_2de5_mux #(.N_DIGITS(1), .PRESCALE(3), .BLANK_CYC(0), .LZB(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One sampled cycle of a 4-digit DUT: bookkeeping of which digit is lit with what glyph.
  task automatic sample(input int d, input logic [6:0] s, input logic [3:0] dg);
    int on;
    on = -1;
    chk($sformatf("onehot%0d", d), 32'($countones(~dg) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) if (!dg[i]) on = i;
    if (on < 0) begin
      chk($sformatf("off_seg%0d", d), 32'(s), 32'(B));
    end else begin
      if (lit[d][on] == 0) seen[d][on] = s;
      else chk($sformatf("seg_hold%0d_%0d", d, on), 32'(s), 32'(seen[d][on]));
      lit[d][on]++;
      if (d == 0) begin
        if (prev_on >= 0 && on != prev_on)
          chk("scan_order", 32'(on), 32'((prev_on + 1) % 4));
        prev_on = on;
      end
    end
  endtask

  // Observe one full scan frame (4 slots x 4 cycles) of both 4-digit DUTs.
  task automatic scan_frame();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        seen[d][i] = B;
        lit[d][i]  = 0;
      end
    prev_on = -1;
    repeat (16) begin
      @(negedge clk);
      sample(0, bus0.seg_n, bus0.dig_n);
      sample(1, bus1.seg_n, bus1.dig_n);
    end
  endtask

  // Present a code for one edge; returns at the following falling edge.
  task automatic do_load(input logic [19:0] c);
    @(negedge clk);
    load = 1'b1;
    code = c;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{{Z, Z, Z, 5'b01100}, {G0, G0, G0, 7'h01}, {B, B, B, 7'h01}, 4'h0};
    vecs[1]  = '{{Z, Z, Z, 5'b11000}, {G0, G0, G0, 7'h4F}, {B, B, B, 7'h4F}, 4'h0};
    vecs[2]  = '{{Z, Z, Z, 5'b10100}, {G0, G0, G0, 7'h12}, {B, B, B, 7'h12}, 4'h0};
    vecs[3]  = '{{Z, Z, Z, 5'b10010}, {G0, G0, G0, 7'h06}, {B, B, B, 7'h06}, 4'h0};
    vecs[4]  = '{{Z, Z, Z, 5'b01010}, {G0, G0, G0, 7'h4C}, {B, B, B, 7'h4C}, 4'h0};
    vecs[5]  = '{{Z, Z, Z, 5'b00110}, {G0, G0, G0, 7'h24}, {B, B, B, 7'h24}, 4'h0};
    vecs[6]  = '{{Z, Z, Z, 5'b10001}, {G0, G0, G0, 7'h20}, {B, B, B, 7'h20}, 4'h0};
    vecs[7]  = '{{Z, Z, Z, 5'b01001}, {G0, G0, G0, 7'h0F}, {B, B, B, 7'h0F}, 4'h0};
    vecs[8]  = '{{Z, Z, Z, 5'b00101}, {G0, G0, G0, 7'h00}, {B, B, B, 7'h00}, 4'h0};
    vecs[9]  = '{{Z, Z, Z, 5'b00011}, {G0, G0, G0, 7'h04}, {B, B, B, 7'h04}, 4'h0};
    vecs[10] = '{{Z, Z, 5'b01010, Z}, {G0, G0, 7'h4C, G0}, {B, B, 7'h4C, G0}, 4'h0};
    vecs[11] = '{{Z, Z, Z, Z}, {G0, G0, G0, G0}, {B, B, B, G0}, 4'h0};
    vecs[12] = '{{Z, 5'b00000, Z, Z}, {G0, 7'h30, G0, G0}, {B, 7'h30, G0, G0}, 4'b0100};
    vecs[13] = '{{Z, 5'b11100, Z, Z}, {G0, 7'h30, G0, G0}, {B, 7'h30, G0, G0}, 4'b0100};
    vecs[14] = '{{Z, Z, Z, Z}, {G0, G0, G0, G0}, {B, B, B, G0}, 4'h0};
    vecs[15] = '{{5'b11111, Z, Z, Z}, {7'h30, G0, G0, G0}, {7'h30, G0, G0, G0}, 4'b1000};
    vecs[16] = '{{5'b00011, 5'b00101, 5'b01001, 5'b10001},
                 {7'h04, 7'h00, 7'h0F, 7'h20}, {7'h04, 7'h00, 7'h0F, 7'h20}, 4'h0};
    vecs[17] = '{{Z, Z, Z, 5'b00001}, {G0, G0, G0, 7'h30}, {B, B, B, 7'h30}, 4'b0001};
    vecs[18] = '{{Z, 5'b10100, Z, Z}, {G0, 7'h12, G0, G0}, {B, 7'h12, G0, G0}, 4'h0};

    // Reset held for three clocks.
    rst_n = 1'b0;
    load  = 1'b0;
    code  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg0", 32'(bus0.seg_n), 32'h7F);
    chk("rst_dig0", 32'(bus0.dig_n), 32'hF);
    chk("rst_err0", 32'(bus0.err), 32'h0);
    chk("rst_seg1", 32'(bus1.seg_n), 32'h7F);
    chk("rst_dig1", 32'(bus1.dig_n), 32'hF);
    chk("rst_dig2", 32'(bus2.dig_n), 32'h1);
    chk("rst_err2", 32'(bus2.err), 32'h0);

    // Release without load: display stays dark.
    rst_n = 1'b1;
    scan_frame();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("preload_lit0_%0d", i), 32'(lit[0][i]), 32'd0);
      chk($sformatf("preload_lit1_%0d", i), 32'(lit[1][i]), 32'd0);
    end
    chk("preload_err0", 32'(bus0.err), 32'h0);

    // Vector table.
    for (int v = 0; v < 19; v++) begin
      do_load(vecs[v].code);
      chk($sformatf("v%0d_err0", v), 32'(bus0.err), 32'(vecs[v].err));
      chk($sformatf("v%0d_err1", v), 32'(bus1.err), 32'(vecs[v].err));
      scan_frame();
      for (int i = 0; i < 4; i++) begin
        logic [6:0] x0, x1;
        x0 = vecs[v].e0[7*i +: 7];
        x1 = vecs[v].e1[7*i +: 7];
        chk($sformatf("v%0d_seg0_d%0d", v, i), 32'(seen[0][i]), 32'(x0));
        chk($sformatf("v%0d_lit0_d%0d", v, i), 32'(lit[0][i]), (x0 == B) ? 32'd0 : 32'd3);
        chk($sformatf("v%0d_seg1_d%0d", v, i), 32'(seen[1][i]), 32'(x1));
        chk($sformatf("v%0d_lit1_d%0d", v, i), 32'(lit[1][i]), (x1 == B) ? 32'd0 : 32'd3);
      end
    end

    // Load in the middle of digit 1's slot: scan timing continues, glyph one clock later.
    begin
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      @(negedge clk);
      prev = bus0.dig_n;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (prev == 4'hF && bus0.dig_n == 4'hD) found = 1'b1;
        else prev = bus0.dig_n;
      end
      chk("find_slot1", 32'(found), 32'd1);
      load = 1'b1;
      code = {Z, 5'b10100, 5'b01010, 5'b00000};
      @(negedge clk);
      load = 1'b0;
      chk("mid_dig_a", 32'(bus0.dig_n), 32'hD);
      chk("mid_seg_old", 32'(bus0.seg_n), 32'h01);
      chk("mid_err", 32'(bus0.err), 32'h1);
      @(negedge clk);
      chk("mid_dig_b", 32'(bus0.dig_n), 32'hD);
      chk("mid_seg_new", 32'(bus0.seg_n), 32'h4C);
      @(negedge clk);
      chk("mid_gap", 32'(bus0.dig_n), 32'hF);
      @(negedge clk);
      chk("mid_next_dig", 32'(bus0.dig_n), 32'hB);
      chk("mid_next_seg", 32'(bus0.seg_n), 32'h12);
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_seg0", 32'(bus0.seg_n), 32'h7F);
    chk("arst_dig0", 32'(bus0.dig_n), 32'hF);
    chk("arst_err0", 32'(bus0.err), 32'h0);
    chk("arst_dig1", 32'(bus1.dig_n), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b1;
    code  = {Z, Z, Z, 5'b10100};
    @(negedge clk);
    load = 1'b0;
    chk("arst_blank_dig", 32'(bus0.dig_n), 32'hF);
    chk("arst_blank_err", 32'(bus0.err), 32'h0);
    @(negedge clk);
    chk("arst_restart_dig", 32'(bus0.dig_n), 32'hE);
    chk("arst_restart_seg", 32'(bus0.seg_n), 32'h12);

    // Single-digit instance with no gap: digit always enabled.
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("n1_dig_%0d", k), 32'(bus2.dig_n), 32'h0);
      chk($sformatf("n1_seg_%0d", k), 32'(bus2.seg_n), 32'h12);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
